// File: rtl/word_ser_pkg.sv
// Shared types and sizing helpers for the word serializer slice.
package word_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Enable-qualified bit counter with synchronous clear; saturates at TERM and flags it.
// No latency beyond one register; clear has priority over enable.
module ser_bit_counter #(
  parameter int CW   = 5,
  parameter int TERM = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          ena_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (ena_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o  = (cnt_q == CW'(TERM));
  assign cnt_o = cnt_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: word accepted on valid/ready, first bit on ser_out the next cycle,
// one bit per clk_ena cycle, din_ready low until the post-frame gap. WORD_SERIALIZER_PARITY_EN appends even parity.
module word_serializer
  import word_ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr_n,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last,
  output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW      = cnt_width(WIDTH);
  localparam int OUT_IDX = LSB_FIRST ? 0 : FL - 1;

  state_t          state_q;
  logic [FL-1:0]   shreg_q;
  logic [FL-1:0]   shreg_d;
  logic [FL-1:0]   load_val;
  logic            din_ready_q;
  logic            ser_out_q;
  logic            ser_frame_q;
  logic            ser_last_q;
  logic            busy_q;
  logic [CW-1:0]   cnt;
  logic            cnt_tc;
  logic            accept;
  logic            advance;

  // Parity rides at the far end of the register so it leaves after the data bits.
`ifdef WORD_SERIALIZER_PARITY_EN
  assign load_val = LSB_FIRST ? {^din, din} : {din, ^din};
`else
  assign load_val = din;
`endif

  assign shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
  assign accept  = sclr_n && (state_q == IDLE) && din_valid && din_ready_q;
  assign advance = sclr_n && (state_q == SHIFT) && clk_ena;

  ser_bit_counter #(
    .CW   (CW),
    .TERM (FL - 1)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!sclr_n || accept),
    .ena_i (advance),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      din_ready_q <= 1'b0;
      ser_out_q   <= 1'b1;
      ser_frame_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (!sclr_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      din_ready_q <= 1'b1;
      ser_out_q   <= 1'b1;
      ser_frame_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SHIFT;
            shreg_q     <= load_val;
            din_ready_q <= 1'b0;
            ser_out_q   <= load_val[OUT_IDX];
            ser_frame_q <= 1'b1;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            din_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (clk_ena) begin
            shreg_q <= shreg_d;
            if (cnt_tc) begin
              state_q     <= GAP;
              ser_out_q   <= 1'b1;
              ser_frame_q <= 1'b0;
              ser_last_q  <= 1'b0;
            end else begin
              ser_out_q  <= shreg_d[OUT_IDX];
              ser_last_q <= (cnt == CW'(FL - 2));
            end
          end
        end
        GAP: begin
          if (clk_ena) begin
            state_q     <= IDLE;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          din_ready_q <= 1'b0;
          ser_out_q   <= 1'b1;
          ser_frame_q <= 1'b0;
          ser_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready = din_ready_q;
  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances share stimulus and a frame-level model.
module tb_word_serializer;

  localparam int W = 16;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = W + PB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclr_n = 1'b1;
  logic         clk_ena = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic rdy0, so0, fr0, la0, bz0;
  logic rdy1, so1, fr1, la1, bz1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclr_n(sclr_n), .clk_ena(clk_ena), .din(din),
    .din_valid(din_valid), .din_ready(rdy0), .ser_out(so0), .ser_frame(fr0),
    .ser_last(la0), .busy(bz0)
  );

  word_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclr_n(sclr_n), .clk_ena(clk_ena), .din(din),
    .din_valid(din_valid), .din_ready(rdy1), .ser_out(so1), .ser_frame(fr1),
    .ser_last(la1), .busy(bz1)
  );

  // Frame-level model: m_pos is the index of the frame bit on the wire, -1 when no frame.
  int           m_pos = -1;
  bit           m_gap = 1'b0;
  bit           m_ready = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_acc_cnt = 0;
  int           m_acc_cyc = 0;
  int           cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   <= -1;
      m_gap   <= 1'b0;
      m_ready <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!sclr_n) begin
        m_pos   <= -1;
        m_gap   <= 1'b0;
        m_ready <= 1'b1;
      end else if (m_pos >= 0) begin
        if (clk_ena) begin
          if (m_pos == FL - 1) begin
            m_pos <= -1;
            m_gap <= 1'b1;
          end else begin
            m_pos <= m_pos + 1;
          end
        end
      end else if (m_gap) begin
        if (clk_ena) begin
          m_gap   <= 1'b0;
          m_ready <= 1'b1;
        end
      end else if (din_valid && m_ready) begin
        m_word    <= din;
        m_pos     <= 0;
        m_ready   <= 1'b0;
        m_acc_cnt <= m_acc_cnt + 1;
        m_acc_cyc <= cyc;
      end else begin
        m_ready <= 1'b1;
      end
    end
  end

  function automatic logic exp_bit(input logic [W-1:0] w, input int p, input bit lsb);
    if (p >= W) return ^w;
    return lsb ? w[p] : w[W-1-p];
  endfunction

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("rdy0",   rdy0, m_ready);
    chk("out0",   so0,  (m_pos >= 0) ? exp_bit(m_word, m_pos, 1'b0) : 1'b1);
    chk("frame0", fr0,  m_pos >= 0);
    chk("last0",  la0,  m_pos == FL - 1);
    chk("busy0",  bz0,  (m_pos >= 0) || m_gap);
    chk("rdy1",   rdy1, m_ready);
    chk("out1",   so1,  (m_pos >= 0) ? exp_bit(m_word, m_pos, 1'b1) : 1'b1);
    chk("frame1", fr1,  m_pos >= 0);
    chk("last1",  la1,  m_pos == FL - 1);
    chk("busy1",  bz1,  (m_pos >= 0) || m_gap);
  end

  // Collector of what actually appeared on the wires, for literal expectations.
  logic        col_clr = 1'b0;
  logic [31:0] cap0 = '0, cap1 = '0;
  logic        par0 = 1'b0;
  int          fpos0 = 0, fcyc0 = 0, last_pos0 = -1;

  always @(negedge clk) begin
    if (col_clr) begin
      cap0 <= '0; cap1 <= '0; par0 <= 1'b0;
      fpos0 <= 0; fcyc0 <= 0; last_pos0 <= -1;
    end else if (fr0) begin
      if (fpos0 < W) begin
        cap0 <= {cap0[30:0], so0};
        cap1 <= {cap1[30:0], so1};
      end else begin
        par0 <= so0;
      end
      if (la0) last_pos0 <= fpos0;
      fpos0 <= fpos0 + 1;
      fcyc0 <= fcyc0 + 1;
    end else begin
      fpos0 <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    col_clr = 1'b1;
    @(negedge clk);
    #1;
    col_clr = 1'b0;
  endtask

  task automatic wait_acc(input int prev);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (m_acc_cnt != prev) ok = 1'b1;
    end
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] w);
    int prev;
    prev = m_acc_cnt;
    din = w;
    din_valid = 1'b1;
    wait_acc(prev);
    din_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy0 && n < 300) begin
      tick();
      n++;
    end
    chk("ready_timeout", rdy0, 1'b1);
  endtask

  initial begin
    int n, a1, a2, prev;
    repeat (3) tick();
    chk("rst_rdy",   rdy0, 1'b0);
    chk("rst_out",   so0,  1'b1);
    chk("rst_frame", fr0,  1'b0);
    chk("rst_busy",  bz0,  1'b0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", rdy0, 1'b1);

    // A5C3 with enable held: frame of FL cycles, one GAP cycle, then ready.
    clk_ena = 1'b1;
    clear_cap();
    send(16'hA5C3);
    wait_ready(n);
    chk_int("ready_edges_a5c3", n, FL + 1);
    chk_int("cap_a5c3_msb",  cap0[15:0], 16'hA5C3);
    chk_int("cap_a5c3_lsb",  cap1[15:0], 16'hC3A5);
    chk_int("frame_len_a5c3", fcyc0, FL);
    chk_int("last_pos_a5c3", last_pos0, FL - 1);

    // LSB-first single one goes out first.
    clear_cap();
    send(16'h0001);
    wait_ready(n);
    chk_int("cap_0001_lsb", cap1[15:0], 16'h8000);
    chk_int("cap_0001_msb", cap0[15:0], 16'h0001);

    // Enable every third cycle: each bit held three cycles.
    clear_cap();
    for (int i = 0; i < 70; i++) begin
      clk_ena = (i % 3 == 0);
      din = 16'h8001;
      din_valid = (i == 0);
      tick();
    end
    clk_ena = 1'b1;
    chk_int("frame_len_8001", fcyc0, 3 * FL);
    wait_ready(n);

    // Synchronous clear after five bits; word offered during the clear is refused.
    clear_cap();
    send(16'hFFFF);
    repeat (5) tick();
    prev = m_acc_cnt;
    sclr_n = 1'b0;
    din = 16'h0F0F;
    din_valid = 1'b1;
    tick();
    chk("sclr_frame", fr0,  1'b0);
    chk("sclr_out",   so0,  1'b1);
    chk("sclr_rdy",   rdy0, 1'b1);
    chk("sclr_busy",  bz0,  1'b0);
    sclr_n = 1'b1;
    clear_cap();
    wait_acc(prev);
    din_valid = 1'b0;
    wait_ready(n);
    chk_int("cap_0f0f", cap0[15:0], 16'h0F0F);
    chk_int("last_pos_0f0f", last_pos0, FL - 1);

    // Back-to-back with din_valid held: second accept on first IDLE cycle after GAP.
    clear_cap();
    prev = m_acc_cnt;
    din = 16'h1234;
    din_valid = 1'b1;
    wait_acc(prev);
    a1 = m_acc_cyc;
    din = 16'hABCD;
    prev = m_acc_cnt;
    wait_acc(prev);
    a2 = m_acc_cyc;
    din_valid = 1'b0;
    chk_int("b2b_spacing", a2 - a1, FL + 2);
    wait_ready(n);
    chk_int("cap_b2b", cap0, 32'h1234ABCD);

`ifdef WORD_SERIALIZER_PARITY_EN
    clear_cap();
    send(16'h0007);
    wait_ready(n);
    chk("par_0007", par0, 1'b1);
    chk_int("last_pos_0007", last_pos0, W);
    clear_cap();
    send(16'h0003);
    wait_ready(n);
    chk("par_0003", par0, 1'b0);
`else
    clear_cap();
    send(16'h0007);
    wait_ready(n);
    chk_int("cap_0007", cap0[15:0], 16'h0007);
    chk_int("last_pos_0007", last_pos0, W - 1);
`endif

    // Asynchronous reset mid-word drops the frame immediately.
    send(16'h5A5A);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out",   so0,  1'b1);
    chk("arst_frame", fr0,  1'b0);
    chk("arst_rdy",   rdy0, 1'b0);
    chk("arst_busy",  bz0,  1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_rdy_back", rdy0, 1'b1);
    clear_cap();
    send(16'hF00F);
    wait_ready(n);
    chk_int("cap_f00f", cap0[15:0], 16'hF00F);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
